// File: rtl/alu_mul_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_sequencer_pkg
//  Description : Shared ALU opcode encodings, widths, FSM state type and the
//                carry helper for the multi-cycle multiply sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_mul_sequencer_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 5;
    localparam int CNT_W  = 5;

    // Encodings shared with the EX-stage ALU
    localparam logic [OP_W-1:0] ALUOP_ADD_DEFAULT = 5'b00000;
    localparam logic [OP_W-1:0] ALUOP_SUB_DEFAULT = 5'b00001;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ABS_A  = 3'd1,
        S_ABS_B  = 3'd2,
        S_ITER   = 3'd3,
        S_NEG_LO = 3'd4,
        S_NEG_HI = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    // An unsigned add wrapped exactly when the sum is smaller than one addend
    function automatic logic add_carry(input logic [DATA_W-1:0] sum,
                                       input logic [DATA_W-1:0] addend);
        return (sum < addend);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_sequencer_if
//  Description : Request/result handshake plus shared-ALU drive bundle for the
//                multiply sequencer. slave = sequencer, master = EX stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_mul_sequencer_if;
    import alu_mul_sequencer_pkg::*;

    // Request / result side
    logic                start;
    logic                is_signed;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic                busy;
    logic                done;
    logic [DATA_W-1:0]   hi;
    logic [DATA_W-1:0]   lo;

    // Shared ALU side
    logic                alu_own;
    logic [DATA_W-1:0]   alu_in1;
    logic [DATA_W-1:0]   alu_in2;
    logic [OP_W-1:0]     alu_op;
    logic [OP_W-1:0]     alu_move;
    logic [DATA_W-1:0]   alu_result;

    modport master (
        output start, is_signed, op_a, op_b, alu_result,
        input  busy, done, hi, lo, alu_own, alu_in1, alu_in2, alu_op, alu_move
    );

    modport slave (
        input  start, is_signed, op_a, op_b, alu_result,
        output busy, done, hi, lo, alu_own, alu_in1, alu_in2, alu_op, alu_move
    );

endinterface
`default_nettype wire

// File: rtl/alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_sequencer
//  Description : MULT/MULTU controller that borrows the EX-stage ALU: optional
//                operand abs, 32 shift-add iterations, optional 64-bit negate.
//                Result appears on {hi,lo} with a one-cycle done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
#(
    parameter logic [OP_W-1:0] ALUOP_ADD = ALUOP_ADD_DEFAULT,
    parameter logic [OP_W-1:0] ALUOP_SUB = ALUOP_SUB_DEFAULT
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    alu_mul_sequencer_if.slave  bus
);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   mcand;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;
    logic                neg;
    logic                z;
    logic                busy_q;
    logic                done_q;

    logic                own_c;
    logic [DATA_W-1:0]   in1_c;
    logic [DATA_W-1:0]   in2_c;
    logic [OP_W-1:0]     op_c;
    logic [DATA_W-1:0]   sum;
    logic                carry;

    // Shift-add step: accumulate the multiplicand only when the current multiplier bit is set
    always_comb begin
        sum   = hi_q;
        carry = 1'b0;
        if (lo_q[0]) begin
            sum   = bus.alu_result;
            carry = add_carry(bus.alu_result, hi_q);
        end
    end

    // ALU drive decoded straight from state; idle/done leave the ALU to the pipeline
    always_comb begin
        own_c = 1'b0;
        in1_c = '0;
        in2_c = '0;
        op_c  = ALUOP_ADD;
        case (state)
            S_ABS_A: begin
                own_c = 1'b1;
                in2_c = mcand;
                op_c  = ALUOP_SUB;
            end
            S_ABS_B, S_NEG_LO: begin
                own_c = 1'b1;
                in2_c = lo_q;
                op_c  = ALUOP_SUB;
            end
            S_ITER: begin
                own_c = 1'b1;
                in1_c = hi_q;
                in2_c = mcand;
            end
            S_NEG_HI: begin
                // ALU held but unused; the high word uses a local incrementer
                own_c = 1'b1;
            end
            default: begin
                own_c = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with registered busy/done and product registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            mcand  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            neg    <= 1'b0;
            z      <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        mcand  <= bus.op_a;
                        lo_q   <= bus.op_b;
                        hi_q   <= '0;
                        cnt    <= '0;
                        neg    <= bus.is_signed & (bus.op_a[DATA_W-1] ^ bus.op_b[DATA_W-1]);
                        busy_q <= 1'b1;
                        state  <= bus.is_signed ? S_ABS_A : S_ITER;
                    end
                end
                S_ABS_A: begin
                    if (mcand[DATA_W-1]) begin
                        mcand <= bus.alu_result;
                    end
                    state <= S_ABS_B;
                end
                S_ABS_B: begin
                    // 0x80000000 negates to itself and is then read as unsigned 2^31
                    if (lo_q[DATA_W-1]) begin
                        lo_q <= bus.alu_result;
                    end
                    state <= S_ITER;
                end
                S_ITER: begin
                    hi_q <= {carry, sum[DATA_W-1:1]};
                    lo_q <= {sum[0], lo_q[DATA_W-1:1]};
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        if (neg) begin
                            state <= S_NEG_LO;
                        end else begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_NEG_LO: begin
                    // A zero low word means the +1 of the two's complement carries into hi
                    lo_q  <= bus.alu_result;
                    z     <= (lo_q == '0);
                    state <= S_NEG_HI;
                end
                S_NEG_HI: begin
                    hi_q   <= ~hi_q + {{(DATA_W-1){1'b0}}, z};
                    state  <= S_DONE;
                    done_q <= 1'b1;
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.alu_own  = own_c;
    assign bus.alu_in1  = in1_c;
    assign bus.alu_in2  = in2_c;
    assign bus.alu_op   = op_c;
    assign bus.alu_move = '0;

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_mul_sequencer
//  Description : Self-checking bench: sequencer + behavioural ALU + EX mux.
//                Products and latencies come from plain 64-bit arithmetic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_mul_sequencer;
    import alu_mul_sequencer_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_mul_sequencer_if bus ();

    alu_mul_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Other EX-stage traffic that the ALU sees whenever the sequencer lets go
    logic [31:0] junk1;
    logic [31:0] junk2;
    logic [4:0]  junk_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_sel;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Randomise pipeline traffic every cycle
    always @(posedge clk) begin
        junk1   <= $urandom;
        junk2   <= $urandom;
        junk_op <= 5'($urandom_range(0, 1));
    end

    // EX mux plus the ALU itself
    always_comb begin
        alu_a   = bus.alu_own ? bus.alu_in1 : junk1;
        alu_b   = bus.alu_own ? bus.alu_in2 : junk2;
        alu_sel = bus.alu_own ? bus.alu_op  : junk_op;
        if (alu_sel == ALUOP_ADD_DEFAULT)
            bus.alu_result = alu_a + alu_b;
        else if (alu_sel == ALUOP_SUB_DEFAULT)
            bus.alu_result = alu_a - alu_b;
        else
            bus.alu_result = alu_a ^ alu_b;
    end

    function automatic logic [63:0] model_product(input logic [31:0] a,
                                                  input logic [31:0] b,
                                                  input logic sgn);
        longint sa;
        longint sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    function automatic int model_latency(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic sgn);
        if (!sgn) return 33;
        if (a[31] ^ b[31]) return 37;
        return 35;
    endfunction

    // Called on a negedge with the sequencer idle; start goes high for that cycle (cycle 0).
    // Returns at the negedge of cycle latency+1 with the sequencer idle again.
    task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                            input string tag, input int ign1, input int ign2);
        logic [63:0] exp_p;
        int          lat;
        logic        exp_busy;
        logic        exp_done;
        logic        exp_own;
        exp_p = model_product(a, b, sgn);
        lat   = model_latency(a, b, sgn);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_before_start busy=%0b want 0", tag, bus.busy);
        end
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.op_a      = a;
        bus.op_b      = b;
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            bus.start     = 1'b0;
            bus.op_a      = $urandom;
            bus.op_b      = $urandom;
            bus.is_signed = 1'($urandom_range(0, 1));
            exp_busy = (k <= lat);
            exp_done = (k == lat);
            exp_own  = (k < lat);
            checks++;
            if (bus.busy !== exp_busy) begin
                errors++;
                $display("FAIL %s busy cycle %0d got %0b want %0b", tag, k, bus.busy, exp_busy);
            end
            checks++;
            if (bus.done !== exp_done) begin
                errors++;
                $display("FAIL %s done cycle %0d got %0b want %0b", tag, k, bus.done, exp_done);
            end
            checks++;
            if (bus.alu_own !== exp_own) begin
                errors++;
                $display("FAIL %s alu_own cycle %0d got %0b want %0b", tag, k, bus.alu_own, exp_own);
            end
            if (k >= lat) begin
                checks++;
                if ({bus.hi, bus.lo} !== exp_p) begin
                    errors++;
                    $display("FAIL %s product cycle %0d a=%h b=%h s=%0b got %h_%h want %h",
                             tag, k, a, b, sgn, bus.hi, bus.lo, exp_p);
                end
            end
            if (k == ign1 || k == ign2) begin
                bus.start = 1'b1;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.alu_own !== 1'b0) begin
            errors++;
            $display("FAIL %s ctrl busy=%0b done=%0b own=%0b want 0 0 0",
                     tag, bus.busy, bus.done, bus.alu_own);
        end
        checks++;
        if (bus.alu_in1 !== 32'd0 || bus.alu_in2 !== 32'd0 ||
            bus.alu_op !== ALUOP_ADD_DEFAULT || bus.alu_move !== 5'd0) begin
            errors++;
            $display("FAIL %s alu_drive in1=%h in2=%h op=%h move=%h want 0 0 %h 0",
                     tag, bus.alu_in1, bus.alu_in2, bus.alu_op, bus.alu_move, ALUOP_ADD_DEFAULT);
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++;
            $display("FAIL reset hilo got %h_%h want 0_0", bus.hi, bus.lo);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");
    endtask

    task automatic test_directed();
        run_mult(32'd3,          32'd5,          1'b0, "multu_3x5",   -1, -1);
        run_mult(32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, "multu_max",   -1, -1);
        run_mult(32'hFFFF_FFFD,  32'd5,          1'b1, "mult_m3x5",   -1, -1);
        run_mult(32'hFFFF_FFFD,  32'hFFFF_FFFB,  1'b1, "mult_m3xm5",  -1, -1);
        run_mult(32'h8000_0000,  32'h8000_0000,  1'b1, "mult_min",    -1, -1);
        run_mult(32'd7,          32'hFFFF_FFFF,  1'b1, "mult_7xm1",   -1, -1);
        run_mult(32'd0,          32'hFFFF_FFFB,  1'b1, "mult_0xm5",   -1, -1);
        run_mult(32'h8000_0000,  32'd1,          1'b1, "mult_minx1",  -1, -1);
        check_idle_outputs("after_directed");
    endtask

    task automatic test_ignored_start();
        run_mult(32'd3, 32'd5, 1'b0, "ign_multu", 5, 33);
        run_mult(32'hFFFF_FFF0, 32'd9, 1'b1, "ign_mult", 5, 37);
    endtask

    task automatic test_back_to_back();
        // run_mult returns in the cycle after DONE, so each call starts there
        run_mult(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, "b2b_0", -1, -1);
        run_mult(32'h8765_4321, 32'h0FED_CBA9, 1'b1, "b2b_1", -1, -1);
        run_mult(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, "b2b_2", -1, -1);
    endtask

    task automatic test_mid_reset();
        int done_seen;
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.op_a      = 32'hFFFF_FFFF;
        bus.op_b      = 32'hFFFF_FFFF;
        repeat (11) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst busy_before got %0b want 1", bus.busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle_outputs("midrst");
        checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++;
            $display("FAIL midrst hilo got %h_%h want 0_0", bus.hi, bus.lo);
        end
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL midrst activity_after_abort got %0d cycles want 0", done_seen);
        end
        run_mult(32'hFFFF_FFFE, 32'd3, 1'b1, "after_midrst", -1, -1);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        for (int n = 0; n < 20; n++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: b = 32'd0;
                2: a = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_mult(a, b, s, "random", -1, -1);
        end
    endtask

    // Absolute bound on the run in case the DUT wedges the handshake
    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_ignored_start();
        test_back_to_back();
        test_mid_reset();
        test_random();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
